// File: rtl/ot_wrr_burst_arb.sv
// Weighted round-robin burst arbiter: N valid/ready sources onto one sink.
// Bursts are atomic; credits reload from cfg_weight when a round runs dry.
module ot_wrr_burst_arb #(
    parameter int IN_CNT     = 4,
    parameter int DATA_WIDTH = 128,
    parameter int WEIGHT_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_CNT-1:0]            in_vld,
    output logic [IN_CNT-1:0]            in_rdy,
    input  logic [IN_CNT*DATA_WIDTH-1:0] in_data,
    input  logic [IN_CNT-1:0]            in_last,
    input  logic [IN_CNT*WEIGHT_W-1:0]   cfg_weight,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic [1:0]                   out_src,
    output logic                         busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [1:0] LAST_IDX = 2'(IN_CNT - 1);

    logic [0:0]          state;
    logic [1:0]          lock;
    logic [1:0]          ptr;
    logic                hold_q;
    logic [1:0]          hold_idx;
    logic [WEIGHT_W-1:0] credit [IN_CNT];

    logic [IN_CNT-1:0]   elig;
    logic                any_elig;
    logic [1:0]          scan_idx;
    logic [1:0]          cand;

    logic [1:0]          src;
    logic                vld;
    logic                reload;

    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_last;
    logic [WEIGHT_W-1:0]   src_credit;
    logic [WEIGHT_W-1:0]   src_credit_dec;

    logic hs;
    logic burst_end;
    logic burst_start;

    function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
        return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

    // A requester may win only while it is valid and holds credit.
    always_comb begin
        for (int i = 0; i < IN_CNT; i++) begin
            elig[i] = in_vld[i] && (credit[i] != '0);
        end
    end

    // First eligible index walking forward from ptr, wrapping.
    always_comb begin
        any_elig = 1'b0;
        scan_idx = ptr;
        cand     = ptr;
        for (int k = 0; k < IN_CNT; k++) begin
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                scan_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    // Pick the source: locked burst, held offer, or a fresh scan.
    always_comb begin
        src    = ptr;
        vld    = 1'b0;
        reload = 1'b0;
        unique case (1'b1)
            (state == BURST): begin
                src = lock;
                vld = in_vld[lock];
            end
            (state == IDLE && hold_q): begin
                src = hold_idx;
                vld = in_vld[hold_idx];
            end
            (state == IDLE && !hold_q): begin
                src    = scan_idx;
                vld    = any_elig;
                reload = (|in_vld) && !any_elig;
            end
            default: begin
                src = ptr;
            end
        endcase
    end

    // Route the selected requester's payload, last flag and credit.
    always_comb begin
        src_data   = '0;
        src_last   = 1'b0;
        src_credit = '0;
        for (int i = 0; i < IN_CNT; i++) begin
            if (src == 2'(i)) begin
                src_data   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                src_last   = in_last[i];
                src_credit = credit[i];
            end
        end
    end

    assign src_credit_dec = (src_credit != '0) ?
                            src_credit - WEIGHT_W'(1) : '0;

    assign hs          = vld && out_rdy;
    assign burst_end   = hs && src_last;
    assign burst_start = hs && !src_last && (state == IDLE);

    assign out_vld  = vld;
    assign out_src  = src;
    assign out_data = vld ? src_data : '0;
    assign out_last = vld && src_last;
    assign busy     = (state == BURST);

    // Only the source that completes a handshake sees ready.
    always_comb begin
        for (int i = 0; i < IN_CNT; i++) begin
            in_rdy[i] = hs && (src == 2'(i));
        end
    end

    // Burst FSM, lock, RR pointer and stalled-offer hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lock     <= 2'd0;
            ptr      <= 2'd0;
            hold_q   <= 1'b0;
            hold_idx <= 2'd0;
        end else begin
            hold_q   <= (state == IDLE) && vld && !out_rdy;
            hold_idx <= src;
            if (burst_end) begin
                state <= IDLE;
                if (src_credit_dec != '0) begin
                    ptr <= src;
                end else begin
                    ptr <= wrap_inc(src);
                end
            end else if (burst_start) begin
                state <= BURST;
                lock  <= src;
            end
        end
    end

    // Credits: reload on a dry round, spend one per completed burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IN_CNT; i++) begin
                credit[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_CNT; i++) begin
                if (reload) begin
                    if (cfg_weight[i*WEIGHT_W +: WEIGHT_W] == '0) begin
                        credit[i] <= WEIGHT_W'(1);
                    end else begin
                        credit[i] <= cfg_weight[i*WEIGHT_W +: WEIGHT_W];
                    end
                end else if (burst_end && (src == 2'(i)) &&
                             (credit[i] != '0)) begin
                    credit[i] <= credit[i] - WEIGHT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ot_wrr_burst_arb.sv
// Directed bench for ot_wrr_burst_arb: per-source beat queues feed the DUT,
// a scoreboard of hand-computed beats is checked by a negedge monitor.
module tb_ot_wrr_burst_arb;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int WW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_vld;
    logic [N-1:0]    in_rdy;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N*WW-1:0] cfg_weight;
    logic            out_vld;
    logic            out_rdy;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_src;
    logic            busy;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
        logic          last;
        logic          busy;
    } exp_t;

    exp_t        sb [$];
    logic [DW:0] mem [N][16];
    int          hd [N];
    int          tl [N];
    logic [N-1:0] gate;

    int errors;
    int checks;

    ot_wrr_burst_arb #(
        .IN_CNT(N),
        .DATA_WIDTH(DW),
        .WEIGHT_W(WW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_vld(in_vld),
        .in_rdy(in_rdy),
        .in_data(in_data),
        .in_last(in_last),
        .cfg_weight(cfg_weight),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .out_data(out_data),
        .out_last(out_last),
        .out_src(out_src),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (hd[i] < tl[i] && !gate[i]) begin
                in_vld[i] = 1'b1;
                {in_last[i], in_data[i*DW +: DW]} = mem[i][hd[i]];
            end else begin
                in_vld[i]          = 1'b0;
                in_last[i]         = 1'b0;
                in_data[i*DW +: DW] = '0;
            end
        end
    endtask

    task automatic put(input int i, input logic [DW-1:0] d, input logic l);
        mem[i][tl[i]] = {l, d};
        tl[i]++;
    endtask

    task automatic ex(input logic [1:0] s, input logic [DW-1:0] d,
                      input logic l, input logic b);
        exp_t e;
        e.src  = s;
        e.data = d;
        e.last = l;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
        end
        gate = '0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        out_rdy = 1'b1;
        flush();
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    function automatic bit drained();
        bit e;
        e = (sb.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (hd[i] != tl[i]) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int c;
        c = 0;
        while (!drained() && c < budget) begin
            step();
            c++;
        end
        checks++;
        if (!drained()) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d beats still expected",
                     name, sb.size());
        end
    endtask

    // Source model: pop a beat after each accepted handshake.
    initial begin
        logic [N-1:0] acc;
        forever begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && hd[i] < tl[i]) hd[i]++;
            end
            drive_inputs();
        end
    end

    // Monitor: every handshake must match the next expected beat.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (rst && out_vld && out_rdy) begin
                got.src  = out_src;
                got.data = out_data;
                got.last = out_last;
                got.busy = busy;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected src=%0d data=%0h",
                             out_src, out_data);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL beat: got src=%0d data=%0h last=%0b busy=%0b want src=%0d data=%0h last=%0b busy=%0b",
                                 got.src, got.data, got.last, got.busy,
                                 e.src, e.data, e.last, e.busy);
                    end
                    chk("in_rdy_onehot", 32'(in_rdy),
                        32'(4'b0001 << out_src));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        out_rdy = 1'b0;
        cfg_weight = '0;
        in_vld = '0;
        in_last = '0;
        in_data = '0;
        flush();

        // reset state
        #3;
        chk("rst_out_vld", 32'(out_vld), 0);
        chk("rst_in_rdy", 32'(in_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_src", 32'(out_src), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);

        // weights {2,1,1,1}, single beats
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd2};
        for (int k = 0; k < 4; k++) put(0, 16'(k), 1'b1);
        for (int i = 1; i < N; i++) begin
            for (int k = 0; k < 2; k++) put(i, 16'(256 * i + k), 1'b1);
        end
        ex(0, 16'h000, 1, 0); ex(0, 16'h001, 1, 0);
        ex(1, 16'h100, 1, 0); ex(2, 16'h200, 1, 0);
        ex(3, 16'h300, 1, 0);
        ex(0, 16'h002, 1, 0); ex(0, 16'h003, 1, 0);
        ex(1, 16'h101, 1, 0); ex(2, 16'h201, 1, 0);
        ex(3, 16'h301, 1, 0);
        drive_inputs();
        @(negedge clk);
        chk("wrr_bubble", 32'(out_vld), 0);
        wait_drain("wrr_2111", 40);

        // 4-beat burst on req0 with req1 waiting
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        put(0, 16'h050, 0); put(0, 16'h051, 0);
        put(0, 16'h052, 0); put(0, 16'h053, 1);
        put(1, 16'h150, 1);
        ex(0, 16'h050, 0, 0); ex(0, 16'h051, 0, 1);
        ex(0, 16'h052, 0, 1); ex(0, 16'h053, 1, 1);
        ex(1, 16'h150, 1, 0);
        drive_inputs();
        wait_drain("burst4", 30);

        // stalls and withdrawal mid-burst
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        put(0, 16'h010, 0); put(0, 16'h011, 0); put(0, 16'h012, 1);
        put(1, 16'h110, 0); put(1, 16'h111, 1);
        ex(0, 16'h010, 0, 0); ex(0, 16'h011, 0, 1);
        ex(0, 16'h012, 1, 1);
        ex(1, 16'h110, 0, 0); ex(1, 16'h111, 1, 1);
        drive_inputs();
        @(negedge clk);
        chk("stall_bubble", 32'(out_vld), 0);
        step();
        step();
        out_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_vld", 32'(out_vld), 1);
            chk("stall_src", 32'(out_src), 0);
            chk("stall_data", 32'(out_data), 32'h011);
            chk("stall_in_rdy", 32'(in_rdy), 0);
            step();
        end
        out_rdy = 1'b1;
        gate[0] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("wd_vld", 32'(out_vld), 0);
            chk("wd_in_rdy", 32'(in_rdy), 0);
            chk("wd_busy", 32'(busy), 1);
            step();
        end
        gate[0] = 1'b0;
        drive_inputs();
        wait_drain("stall_burst", 30);

        // offer held while waiting, despite higher priority arrival
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        out_rdy = 1'b0;
        put(1, 16'h150, 1);
        ex(1, 16'h150, 1, 0);
        ex(0, 16'h050, 1, 0);
        drive_inputs();
        @(negedge clk);
        chk("hold_bubble", 32'(out_vld), 0);
        step();
        @(negedge clk);
        chk("hold_vld", 32'(out_vld), 1);
        chk("hold_src0", 32'(out_src), 1);
        step();
        put(0, 16'h050, 1);
        drive_inputs();
        @(negedge clk);
        chk("hold_src1", 32'(out_src), 1);
        chk("hold_data", 32'(out_data), 32'h150);
        step();
        out_rdy = 1'b1;
        wait_drain("hold", 20);

        // weight 0 on req2 acts as 1
        do_reset();
        cfg_weight = {4'd1, 4'd0, 4'd1, 4'd1};
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 2; k++) put(i, 16'(256 * i + 64 + k), 1'b1);
        end
        ex(0, 16'h040, 1, 0); ex(1, 16'h140, 1, 0);
        ex(2, 16'h240, 1, 0); ex(3, 16'h340, 1, 0);
        ex(0, 16'h041, 1, 0); ex(1, 16'h141, 1, 0);
        ex(2, 16'h241, 1, 0); ex(3, 16'h341, 1, 0);
        drive_inputs();
        wait_drain("weight0", 30);

        // reset during beat 2 of a 3-beat burst
        do_reset();
        cfg_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        put(0, 16'h020, 1);
        put(2, 16'h220, 0); put(2, 16'h221, 0); put(2, 16'h222, 1);
        ex(0, 16'h020, 1, 0);
        ex(2, 16'h220, 0, 0);
        drive_inputs();
        step();
        step();
        step();
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_src", 32'(out_src), 2);
        rst = 1'b0;
        #1;
        chk("arst_out_vld", 32'(out_vld), 0);
        chk("arst_in_rdy", 32'(in_rdy), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_out_src", 32'(out_src), 0);
        chk("arst_out_last", 32'(out_last), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_sb_empty", 32'(sb.size()), 0);
        flush();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        put(0, 16'h030, 1);
        put(1, 16'h130, 1);
        ex(0, 16'h030, 1, 0);
        ex(1, 16'h130, 1, 0);
        drive_inputs();
        @(negedge clk);
        chk("post_rst_bubble", 32'(out_vld), 0);
        wait_drain("post_rst", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ot_wrr_burst_arb.md
OT_WRR_BURST_ARB -- requirements
Module: ot_wrr_burst_arb

Interface
REQ-001 Parameter IN_CNT, default 4, SHALL set the number of requesters; legal range 2..4.
REQ-002 Parameter DATA_WIDTH, default 128, SHALL set the payload width.
REQ-003 Parameter WEIGHT_W, default 4, SHALL set the width of each weight and credit counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 in_vld  input  IN_CNT  SHALL flag a valid beat per requester.
REQ-007 in_rdy  output  IN_CNT  SHALL flag acceptance per requester.
REQ-008 in_data  input  IN_CNT x DATA_WIDTH  SHALL carry per-requester payload.
REQ-009 in_last  input  IN_CNT  SHALL mark the final beat of a burst.
REQ-010 cfg_weight  input  IN_CNT x WEIGHT_W  SHALL give bursts per round per requester.
REQ-011 out_vld / out_rdy / out_data / out_last  output/input/output/output  1/1/DATA_WIDTH/1  SHALL form the shared valid-ready output.
REQ-012 out_src  output  2  SHALL give the index of the requester driving the output.
REQ-013 busy  output  1  SHALL be 1 while in state BURST.

Function
REQ-014 State SHALL be: FSM {IDLE, BURST}, lock index, RR pointer ptr, one credit counter per requester.
REQ-015 Eligible(i) SHALL be in_vld[i]=1 and credit[i]!=0.
REQ-016 In IDLE, sel SHALL be the first eligible index scanning ptr, ptr+1, ... modulo IN_CNT.
REQ-017 In IDLE with at least one eligible requester: out_vld=1, out_src=sel, out_data/out_last from sel, same cycle (zero latency).
REQ-018 In BURST: out_vld=in_vld[lock], out_src=lock, data/last from lock; other requesters SHALL NOT be selected.
REQ-019 in_rdy[i] SHALL be out_rdy AND out_vld AND out_src==i; every other in_rdy bit 0.
REQ-020 IDLE handshake with out_last=0 SHALL move to BURST with lock=sel.
REQ-021 A burst SHALL end on handshake with out_last=1: from IDLE (single-beat) or BURST; FSM returns/stays IDLE.
REQ-022 On burst end, credit[src] SHALL decrement by 1; ptr SHALL stay at src if the new credit is nonzero, else ptr=(src+1) mod IN_CNT.
REQ-023 In IDLE, if some in_vld=1 but no requester is eligible: out_vld=0 that cycle, all credit[i] <= max(cfg_weight[i],1); arbitration resumes next cycle (one-cycle reload bubble).
REQ-024 cfg_weight SHALL be sampled only at reload; changes mid-round take effect at next reload.
REQ-025 Weight 0 SHALL behave as weight 1.
REQ-026 Withdrawal of in_vld[lock] in BURST SHALL only deassert out_vld; lock held until the last beat.
REQ-027 out_vld=1 with out_rdy=0 SHALL hold out_src and data stable (sel fixed while waiting, even if higher-priority requesters assert).
REQ-028 Credits SHALL never underflow; decrement only from nonzero.

Reset
REQ-029 On rst low (asynchronous): FSM=IDLE, lock=0, ptr=0, all credits=0.
REQ-030 During and after reset until first request: out_vld=0, in_rdy=0, busy=0, out_src=0, out_last=0, out_data=0.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately; no state retained.
REQ-032 First request after reset SHALL incur the REQ-023 reload bubble.

Verification
REQ-033 Weights {2,1,1,1}, all single-beat, all valid, out_rdy=1 -> after one bubble, out_src sequence 0,0,1,2,3, bubble, 0,0,1,...
REQ-034 Req0 4-beat burst, req1 valid throughout -> out_src=0 for 4 handshakes, busy=1 beats 2-4, then out_src=1.
REQ-035 Mid-burst out_rdy=0 for 3 cycles and in_vld[lock]=0 for 2 -> no beat lost/duplicated, lock unchanged, in_rdy[other]=0.
REQ-036 Weight 0 on req2, others 1, all valid -> req2 served once per round, sequence 0,1,2,3.
REQ-037 rst low during beat 2 of a 3-beat burst -> outputs per REQ-030 asynchronously; after release next grant preceded by one bubble, starts from ptr=0.
